alu_flag_unit: RTL and testbench

Registered, parametrised status-flag unit for the RV32I ALU datapath. It derives N/Z/C/B/V flags for the current ALU operation from the operands and result. The flags are captured on a valid strobe and held for the branch/compare logic. The unit also keeps sticky carry/overflow bits and a saturating overflow-event counter for the debug/peripheral status register.

---
 rtl/alu_flag_unit.sv | 129 ++++++++++++
 tb/tb_alu_flag_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_flag_unit.sv
// Registered N/Z/C/B/V status flags for the RV32I ALU, plus sticky carry/overflow
// bits and a saturating overflow-event counter for the debug status register.
module alu_flag_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_result,
  input  logic             i_sticky_clr,
  input  logic             i_cnt_clr,
  output logic             o_valid,
  output logic             negative,
  output logic             zero,
  output logic             borrow,
  output logic             carry_out,
  output logic             overflow,
  output logic             sticky_carry,
  output logic             sticky_ovf,
  output logic [CNT_W-1:0] ovf_count,
  output logic             cnt_sat
);

  localparam int unsigned M = WIDTH - 1;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b1000
  } alu_op_e;

  logic [WIDTH:0]   sum, diff;
  logic             n_c, z_c, b_c, c_c, v_c;
  logic             valid_q;
  logic             neg_q, zero_q, borrow_q, carry_q, ovf_q;
  logic             neg_d, zero_d, borrow_d, carry_d, ovf_d;
  logic             sticky_c_q, sticky_c_d, sticky_v_q, sticky_v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;

  assign sum  = {1'b0, i_a} + {1'b0, i_b};
  assign diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    n_c = 1'b0;
    b_c = 1'b0;
    c_c = 1'b0;
    v_c = 1'b0;
    z_c = (i_result == '0);
    case (alu_sel)
      OP_ADD: begin
        n_c = i_result[M];
        c_c = sum[WIDTH];
        v_c = (i_a[M] == i_b[M]) && (i_result[M] != i_a[M]);
      end
      OP_SUB: begin
        n_c = i_result[M];
        // The borrow out of the widened difference is exactly unsigned a < b.
        b_c = diff[WIDTH];
        v_c = (i_a[M] != i_b[M]) && (i_result[M] != i_a[M]);
      end
      default: ;
    endcase
  end

  always_comb begin
    neg_d    = neg_q;
    zero_d   = zero_q;
    borrow_d = borrow_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    if (i_valid) begin
      neg_d    = n_c;
      zero_d   = z_c;
      borrow_d = b_c;
      carry_d  = c_c;
      ovf_d    = v_c;
    end
  end

  // Clear is applied first so that a same-cycle setting capture wins.
  always_comb begin
    sticky_c_d = (sticky_c_q && !i_sticky_clr) || (i_valid && c_c);
    sticky_v_d = (sticky_v_q && !i_sticky_clr) || (i_valid && v_c);
    cnt_base   = i_cnt_clr ? '0 : cnt_q;
    cnt_d      = cnt_base;
    if (i_valid && v_c && (cnt_base != '1)) begin
      cnt_d = cnt_base + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      neg_q      <= 1'b0;
      zero_q     <= 1'b0;
      borrow_q   <= 1'b0;
      carry_q    <= 1'b0;
      ovf_q      <= 1'b0;
      sticky_c_q <= 1'b0;
      sticky_v_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= i_valid;
      neg_q      <= neg_d;
      zero_q     <= zero_d;
      borrow_q   <= borrow_d;
      carry_q    <= carry_d;
      ovf_q      <= ovf_d;
      sticky_c_q <= sticky_c_d;
      sticky_v_q <= sticky_v_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_valid      = valid_q;
  assign negative     = neg_q;
  assign zero         = zero_q;
  assign borrow       = borrow_q;
  assign carry_out    = carry_q;
  assign overflow     = ovf_q;
  assign sticky_carry = sticky_c_q;
  assign sticky_ovf   = sticky_v_q;
  assign ovf_count    = cnt_q;
  assign cnt_sat      = &cnt_q;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed bench for alu_flag_unit: a default (CNT_W=16) instance and a CNT_W=2
// instance share one stimulus stream so counter saturation is reachable quickly.
module tb_alu_flag_unit;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [3:0]  alu_sel;
  logic [31:0] i_a, i_b, i_result;
  logic        i_sticky_clr, i_cnt_clr;

  logic        o_valid, negative, zero, borrow, carry_out, overflow;
  logic        sticky_carry, sticky_ovf, cnt_sat;
  logic [15:0] ovf_count;

  logic        o_valid2, negative2, zero2, borrow2, carry_out2, overflow2;
  logic        sticky_carry2, sticky_ovf2, cnt_sat2;
  logic [1:0]  ovf_count2;

  logic [5:0]  flags, flags2;
  assign flags  = {o_valid,  negative,  zero,  borrow,  carry_out,  overflow};
  assign flags2 = {o_valid2, negative2, zero2, borrow2, carry_out2, overflow2};

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [3:0] ADD = 4'b0000;
  localparam logic [3:0] SUB = 4'b1000;
  localparam logic [3:0] AND = 4'b0111;

  alu_flag_unit #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .alu_sel(alu_sel),
    .i_a(i_a), .i_b(i_b), .i_result(i_result),
    .i_sticky_clr(i_sticky_clr), .i_cnt_clr(i_cnt_clr),
    .o_valid(o_valid), .negative(negative), .zero(zero), .borrow(borrow),
    .carry_out(carry_out), .overflow(overflow),
    .sticky_carry(sticky_carry), .sticky_ovf(sticky_ovf),
    .ovf_count(ovf_count), .cnt_sat(cnt_sat)
  );

  alu_flag_unit #(.WIDTH(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .alu_sel(alu_sel),
    .i_a(i_a), .i_b(i_b), .i_result(i_result),
    .i_sticky_clr(i_sticky_clr), .i_cnt_clr(i_cnt_clr),
    .o_valid(o_valid2), .negative(negative2), .zero(zero2), .borrow(borrow2),
    .carry_out(carry_out2), .overflow(overflow2),
    .sticky_carry(sticky_carry2), .sticky_ovf(sticky_ovf2),
    .ovf_count(ovf_count2), .cnt_sat(cnt_sat2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then advance to 1 time unit after the capturing edge.
  task automatic op(input logic v, input logic [3:0] sel, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] r,
                    input logic sclr, input logic cclr);
    i_valid = v; alu_sel = sel; i_a = a; i_b = b; i_result = r;
    i_sticky_clr = sclr; i_cnt_clr = cclr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    i_valid = 0; alu_sel = ADD; i_a = 0; i_b = 0; i_result = 0;
    i_sticky_clr = 0; i_cnt_clr = 0;
    rst_n = 1;
    #2 rst_n = 0;
    #2;
    n_checks++;
    if ({flags, sticky_carry, sticky_ovf, ovf_count, cnt_sat} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got flags=%b sc=%b so=%b cnt=%0d sat=%b, want all 0",
               flags, sticky_carry, sticky_ovf, ovf_count, cnt_sat);
    end
    n_checks++;
    if ({flags2, sticky_carry2, sticky_ovf2, ovf_count2, cnt_sat2} !== '0) begin
      n_fail++;
      $display("FAIL reset_state2: got flags=%b cnt=%0d sat=%b, want all 0",
               flags2, ovf_count2, cnt_sat2);
    end
    @(posedge clk);
    #7 rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add_overflow;
    op(1, ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 0);
    n_checks++;
    if (flags !== 6'b110001) begin
      n_fail++;
      $display("FAIL add_ovf_flags: got vNZBCV=%b, want 110001", flags);
    end
    n_checks++;
    if (sticky_ovf !== 1'b1 || ovf_count !== 16'd1 || sticky_carry !== 1'b0) begin
      n_fail++;
      $display("FAIL add_ovf_sticky: got so=%b sc=%b cnt=%0d, want so=1 sc=0 cnt=1",
               sticky_ovf, sticky_carry, ovf_count);
    end
  endtask

  task automatic test_sub;
    op(1, SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 0, 0);
    n_checks++;
    if (flags !== 6'b110100) begin
      n_fail++;
      $display("FAIL sub_borrow: got vNZBCV=%b, want 110100", flags);
    end
    op(1, SUB, 32'd9, 32'd9, 32'd0, 0, 0);
    n_checks++;
    if (flags !== 6'b101000) begin
      n_fail++;
      $display("FAIL sub_equal: got vNZBCV=%b, want 101000", flags);
    end
    // Signed overflow on subtract: 0x80000000 - 1 = 0x7FFFFFFF.
    op(1, SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 0, 0);
    n_checks++;
    if (flags !== 6'b100001 || ovf_count !== 16'd2) begin
      n_fail++;
      $display("FAIL sub_ovf: got vNZBCV=%b cnt=%0d, want 100001 cnt=2", flags, ovf_count);
    end
  endtask

  task automatic test_carry_and_hold;
    op(1, ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 0);
    n_checks++;
    if (flags !== 6'b101010 || sticky_carry !== 1'b1) begin
      n_fail++;
      $display("FAIL add_carry: got vNZBCV=%b sc=%b, want 101010 sc=1", flags, sticky_carry);
    end
    op(1, AND, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0, 0, 0);
    n_checks++;
    if (flags !== 6'b101000 || sticky_carry !== 1'b1) begin
      n_fail++;
      $display("FAIL logic_op: got vNZBCV=%b sc=%b, want 101000 sc=1", flags, sticky_carry);
    end
    for (int i = 0; i < 3; i++) begin
      op(0, ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234, 0, 0);
      n_checks++;
      if (flags !== 6'b001000) begin
        n_fail++;
        $display("FAIL idle_hold[%0d]: got vNZBCV=%b, want 001000", i, flags);
      end
    end
  endtask

  task automatic test_clear_collision;
    op(1, ADD, 32'h4000_0000, 32'h4000_0000, 32'h8000_0000, 1, 1);
    n_checks++;
    if (sticky_ovf !== 1'b1 || ovf_count !== 16'd1 || sticky_carry !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_collision: got so=%b sc=%b cnt=%0d, want so=1 sc=0 cnt=1",
               sticky_ovf, sticky_carry, ovf_count);
    end
    op(0, ADD, 32'h0, 32'h0, 32'h0, 1, 1);
    n_checks++;
    if (sticky_ovf !== 1'b0 || ovf_count !== 16'd0 || ovf_count2 !== 2'd0 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_alone: got so=%b cnt=%0d cnt2=%0d ov=%b, want 0 0 0 0",
               sticky_ovf, ovf_count, ovf_count2, o_valid);
    end
  endtask

  task automatic test_back_to_back_saturation;
    logic [1:0] exp2 [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      op(1, ADD, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 0, 0);
      n_checks++;
      if (ovf_count2 !== exp2[i] || cnt_sat2 !== (i >= 2) || o_valid2 !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_cnt2[%0d]: got cnt=%0d sat=%b ov=%b, want cnt=%0d sat=%b ov=1",
                 i, ovf_count2, cnt_sat2, o_valid2, exp2[i], (i >= 2));
      end
      n_checks++;
      if (ovf_count !== 16'(i + 1) || cnt_sat !== 1'b0) begin
        n_fail++;
        $display("FAIL sat_cnt16[%0d]: got cnt=%0d sat=%b, want cnt=%0d sat=0",
                 i, ovf_count, cnt_sat, i + 1);
      end
    end
    op(0, ADD, 32'h0, 32'h0, 32'h0, 0, 1);
    n_checks++;
    if (ovf_count2 !== 2'd0 || cnt_sat2 !== 1'b0 || sticky_ovf2 !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_clear: got cnt=%0d sat=%b so=%b, want cnt=0 sat=0 so=1",
               ovf_count2, cnt_sat2, sticky_ovf2);
    end
  endtask

  task automatic test_reset_midstream;
    op(1, ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 0);
    op(1, ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 0);
    op(1, ADD, 32'hFFFF_FFFF, 32'h2, 32'h1, 0, 0);
    n_checks++;
    if (ovf_count2 !== 2'd2 || sticky_carry2 !== 1'b1 || sticky_ovf2 !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: got cnt=%0d sc=%b so=%b, want cnt=2 sc=1 so=1",
               ovf_count2, sticky_carry2, sticky_ovf2);
    end
    rst_n = 0;
    #2;
    n_checks++;
    if ({flags2, sticky_carry2, sticky_ovf2, ovf_count2, cnt_sat2} !== '0 ||
        {flags, sticky_carry, sticky_ovf, ovf_count, cnt_sat} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got flags=%b sc=%b so=%b cnt=%0d, want all 0",
               flags2, sticky_carry2, sticky_ovf2, ovf_count2);
    end
    #1 rst_n = 1;
    op(1, ADD, 32'd1, 32'd1, 32'd2, 0, 0);
    n_checks++;
    if (flags !== 6'b100000 || ovf_count !== 16'd0 || sticky_carry !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: got vNZBCV=%b cnt=%0d sc=%b, want 100000 cnt=0 sc=0",
               flags, ovf_count, sticky_carry);
    end
  endtask

  initial begin
    test_reset;
    test_add_overflow;
    test_sub;
    test_carry_and_hold;
    test_clear_collision;
    test_back_to_back_saturation;
    test_reset_midstream;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
